hssl_pkt_dispatcher: RTL and testbench
======================================

Name: hssl_pkt_dispatcher

Overview:
Upstream stage of the HSSL interface. It accepts one packet stream from the DVS/routing front end and steers each packet to one of NUM_CHANS spiNNlink transmit channels using key bits. Each channel has one output register that feeds the txpkt_* channel inputs of the HSSL interface. Packets blocked for longer than a programmable time, or offered while the link handshake is incomplete, are dropped and counted.

Parameters:
NUM_CHANS, 8, number of output channels (power of 2)
PKT_BITS, 72, packet width (SpiNNaker header + key + payload)
CHAN_LSB, 8, LSB of channel-select field in packet (key bit 0); field width CB = log2(NUM_CHANS)
DW_BITS, 16, width of drop-wait configuration

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
handshake_complete_in  in  1  link handshake done; 0 = link down
drop_wait_in  in  DW_BITS  cycles a head packet may stall before drop; 0 = never drop on stall
ipkt_data_in  in  PKT_BITS  input packet
ipkt_vld_in  in  1  input valid
ipkt_rdy_out  out  1  input ready (registered)
txpkt_data_out  out  PKT_BITS x NUM_CHANS  per-channel packet (unpacked array)
txpkt_vld_out  out  1 x NUM_CHANS  per-channel valid
txpkt_rdy_in  in  1 x NUM_CHANS  per-channel ready
drop_out  out  1  one-cycle pulse per dropped packet (registered)
drop_cnt_out  out  32  saturating drop count

Behaviour:
- Reset: ipkt_rdy_out=0, all txpkt_vld_out=0, drop_out=0, drop_cnt_out=0, input buffer empty, wait counter 0. ipkt_rdy_out rises on the first clk edge after reset deasserts.
- Input buffer: 2-entry FIFO. Push on ipkt_vld_in && ipkt_rdy_out. ipkt_rdy_out is registered as next_count<2. No combinational path from txpkt_rdy_in to ipkt_rdy_out. Push and pop in the same cycle leave count unchanged.
- Head channel: c = head[CHAN_LSB +: CB].
- Transfer: when the head is valid, handshake_complete_in=1, and (txpkt_vld_out[c]=0 || txpkt_rdy_in[c]=1), the head moves into out register c and is popped in the same cycle. At most one transfer per cycle.
- Latency: a packet accepted at edge N with an empty FIFO and free channel has txpkt_vld_out high after edge N+2. Sustained throughput is 1 pkt/cycle when channels are ready.
- Output register c: cleared when txpkt_vld_out[c]&&txpkt_rdy_in[c] and there is no new transfer to c. Data and valid are held stable while valid && !ready.
- Stall counter: increments each cycle the head is valid, the link is up, and the transfer is blocked. It resets to 0 on any pop. If drop_wait_in!=0 and the counter equals drop_wait_in-1 while still blocked, the head is popped without transfer (drop). drop_wait_in=1 therefore drops on the first blocked cycle. A change to drop_wait_in takes effect immediately against the current count; use a >= compare so a lowered value drops on the next blocked cycle.
- Link down (handshake_complete_in=0):
  - The head is dropped every cycle it is valid; stall counter held at 0.
  - All out registers are cleared (txpkt_vld_out=0) on the next edge without counting. This is the only case valid is withdrawn before ready.
  - ipkt_rdy_out keeps normal FIFO behaviour, so input drains.
- Drop accounting: drop_out pulses for one cycle in the cycle after each drop. drop_cnt_out increments by 1 per drop and saturates at 32'hFFFF_FFFF, with no wrap.
- Reset mid-operation: all buffered and output packets are discarded immediately (async), and no drop is counted.

Test Plan:
- Link up, all rdy=1, send 16 back-to-back packets with key[2:0]=0..7 twice -> each appears on channel key[2:0] 2 cycles after acceptance, order preserved per channel, ipkt_rdy_out stays 1, drop_cnt_out=0.
- txpkt_rdy_in[3]=0, drop_wait_in=0, send 3 packets to ch3 -> ch3 holds pkt1 stable, FIFO fills, ipkt_rdy_out=0 indefinitely, no drops; raise rdy -> all 3 delivered in order.
- txpkt_rdy_in[5]=0, drop_wait_in=4, send 2 packets to ch5 -> pkt1 held on ch5, pkt2 dropped after 4 blocked cycles, drop_out single pulse, drop_cnt_out=1.
- handshake_complete_in=0 with ch1 valid and 2 queued packets -> txpkt_vld_out[1]=0 next cycle, 2 drops on consecutive cycles, drop_cnt_out=2; reassert link -> new traffic flows normally.
- Preload counter to 32'hFFFF_FFFE via forced drops (link down), drop 3 more -> drop_cnt_out=32'hFFFF_FFFF, no wrap.
- Assert reset while FIFO full and outputs valid -> all valid 0, ipkt_rdy_out=0 immediately, ipkt_rdy_out=1 one edge after release.

Source files
------------

// File: rtl/hssl_pkt_dispatcher.sv
// HSSL packet dispatcher: steers one input packet stream onto NUM_CHANS
// spiNNlink transmit channel registers, dropping stalled or link-down packets.
module hssl_pkt_dispatcher #(
   parameter int NUM_CHANS = 8,
   parameter int PKT_BITS  = 72,
   parameter int CHAN_LSB  = 8,
   parameter int DW_BITS   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                handshake_complete_in,
   input  logic [DW_BITS-1:0]  drop_wait_in,
   input  logic [PKT_BITS-1:0] ipkt_data_in,
   input  logic                ipkt_vld_in,
   output logic                ipkt_rdy_out,
   output logic [PKT_BITS-1:0] txpkt_data_out [NUM_CHANS],
   output logic [NUM_CHANS-1:0] txpkt_vld_out,
   input  logic [NUM_CHANS-1:0] txpkt_rdy_in,
   output logic                drop_out,
   output logic [31:0]         drop_cnt_out
);

   localparam int CB = $clog2(NUM_CHANS);

   logic                 link;
   logic [PKT_BITS-1:0]  in_q, in_d;
   logic                 in_vld_q, in_vld_d;
   logic [PKT_BITS-1:0]  fifo_q [2];
   logic [PKT_BITS-1:0]  fifo_d [2];
   logic [1:0]           cnt_q, cnt_d;
   logic                 rdy_q, rdy_d;
   logic [PKT_BITS-1:0]  out_q [NUM_CHANS];
   logic [PKT_BITS-1:0]  out_d [NUM_CHANS];
   logic [NUM_CHANS-1:0] out_vld_q, out_vld_d;
   logic [DW_BITS-1:0]   stall_q, stall_d;
   logic                 drop_q;
   logic [31:0]          drop_cnt_q, drop_cnt_d;

   logic [PKT_BITS-1:0]  head;
   logic                 head_vld;
   logic [CB-1:0]        head_ch;
   logic                 ch_free;
   logic                 xfer;
   logic                 blocked;
   logic                 stall_hit;
   logic                 drop;
   logic                 pop;
   logic                 push;
   logic                 mv;

   assign link     = handshake_complete_in;
   assign head     = fifo_q[0];
   assign head_vld = (cnt_q != 2'd0);
   assign head_ch  = head[CHAN_LSB +: CB];
   assign ch_free  = !out_vld_q[head_ch] || txpkt_rdy_in[head_ch];
   assign xfer     = head_vld && link && ch_free;
   assign blocked  = head_vld && link && !ch_free;

   assign stall_hit = (drop_wait_in != '0) &&
                      (stall_q >= (drop_wait_in - DW_BITS'(1)));
   assign drop = head_vld && (!link || (blocked && stall_hit));
   assign pop  = xfer || drop;
   assign push = ipkt_vld_in && rdy_q;

   // The input register always has room to move on, because ready is only
   // granted while the FIFO can absorb whatever sits in it.
   assign mv = in_vld_q && ((cnt_q != 2'd2) || pop);

   always_comb begin
      in_d     = in_q;
      in_vld_d = in_vld_q;
      if (mv) in_vld_d = 1'b0;
      if (push) begin
         in_d     = ipkt_data_in;
         in_vld_d = 1'b1;
      end
   end

   always_comb begin
      fifo_d = fifo_q;
      cnt_d  = cnt_q;
      if (pop) begin
         fifo_d[0] = fifo_q[1];
         cnt_d     = cnt_q - 2'd1;
      end
      if (mv) begin
         fifo_d[cnt_d[0]] = in_q;
         cnt_d            = cnt_d + 2'd1;
      end
      rdy_d = (cnt_d < 2'd2);
   end

   always_comb begin
      stall_d = stall_q;
      if (!link || pop) begin
         stall_d = '0;
      end else if (blocked && (stall_q != '1)) begin
         stall_d = stall_q + DW_BITS'(1);
      end
   end

   // Link loss withdraws every pending output without acknowledgement.
   always_comb begin
      out_d     = out_q;
      out_vld_d = '0;
      for (int i = 0; i < NUM_CHANS; i++) begin
         out_vld_d[i] = out_vld_q[i] && !txpkt_rdy_in[i];
         if (xfer && (head_ch == CB'(i))) begin
            out_d[i]     = head;
            out_vld_d[i] = 1'b1;
         end
         if (!link) out_vld_d[i] = 1'b0;
      end
   end

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
         drop_cnt_d = drop_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_q       <= '0;
         in_vld_q   <= 1'b0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         cnt_q      <= 2'd0;
         rdy_q      <= 1'b0;
         out_vld_q  <= '0;
         stall_q    <= '0;
         drop_q     <= 1'b0;
         drop_cnt_q <= '0;
         for (int i = 0; i < NUM_CHANS; i++) out_q[i] <= '0;
      end else begin
         in_q       <= in_d;
         in_vld_q   <= in_vld_d;
         fifo_q     <= fifo_d;
         cnt_q      <= cnt_d;
         rdy_q      <= rdy_d;
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         stall_q    <= stall_d;
         drop_q     <= drop;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign ipkt_rdy_out   = rdy_q;
   assign txpkt_data_out = out_q;
   assign txpkt_vld_out  = out_vld_q;
   assign drop_out       = drop_q;
   assign drop_cnt_out   = drop_cnt_q;

   no_in_overrun: assert property (
      @(posedge clk) disable iff (reset) !(push && in_vld_q && !mv));

endmodule

// File: tb/tb_hssl_pkt_dispatcher.sv
// Directed testbench for hssl_pkt_dispatcher: routing, stall hold,
// stall drops, link-down drops, counter saturation and async reset.
module tb_hssl_pkt_dispatcher;

   logic        clk = 1'b0;
   logic        reset;
   logic        hs;
   logic [15:0] dw;
   logic [71:0] din;
   logic        vld;
   logic        rdy_o;
   logic [71:0] tdata [8];
   logic [7:0]  tvld;
   logic [7:0]  trdy;
   logic        drop;
   logic [31:0] dcnt;

   int errs   = 0;
   int checks = 0;
   int exp_drops = 0;

   hssl_pkt_dispatcher dut (
      .clk                   (clk),
      .reset                 (reset),
      .handshake_complete_in (hs),
      .drop_wait_in          (dw),
      .ipkt_data_in          (din),
      .ipkt_vld_in           (vld),
      .ipkt_rdy_out          (rdy_o),
      .txpkt_data_out        (tdata),
      .txpkt_vld_out         (tvld),
      .txpkt_rdy_in          (trdy),
      .drop_out              (drop),
      .drop_cnt_out          (dcnt)
   );

   always #5 clk = ~clk;

   function automatic logic [71:0] mk(input int id, input int ch);
      logic [71:0] p;
      p        = '0;
      p[7:0]   = 8'(id);
      p[10:8]  = 3'(ch);
      p[23:16] = 8'(id) ^ 8'h5A;
      p[71:64] = 8'(id);
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (rdy_o !== 1'b0 || tvld !== 8'h00 || drop !== 1'b0 || dcnt !== 32'd0) begin
         errs++;
         $display("FAIL reset_state: rdy=%b vld=%h drop=%b cnt=%h want 0 00 0 0",
                  rdy_o, tvld, drop, dcnt);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (rdy_o !== 1'b0) begin
         errs++;
         $display("FAIL reset_release_pre_edge: rdy=%b want 0", rdy_o);
      end
      tick();
      checks++;
      if (rdy_o !== 1'b1) begin
         errs++;
         $display("FAIL reset_release_edge: rdy=%b want 1", rdy_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ev;
      for (int t = 0; t < 18; t++) begin
         if (t < 16) begin
            vld = 1'b1;
            din = mk(t, t % 8);
         end else begin
            vld = 1'b0;
         end
         tick();
         ev = (t >= 2) ? (8'b1 << ((t - 2) % 8)) : 8'h00;
         checks++;
         if (tvld !== ev) begin
            errs++;
            $display("FAIL b2b_vld t=%0d: got %h want %h", t, tvld, ev);
         end
         if (t >= 2) begin
            checks++;
            if (tdata[(t - 2) % 8] !== mk(t - 2, (t - 2) % 8)) begin
               errs++;
               $display("FAIL b2b_data t=%0d: got %h want %h", t,
                        tdata[(t - 2) % 8], mk(t - 2, (t - 2) % 8));
            end
         end
         checks++;
         if (rdy_o !== 1'b1) begin
            errs++;
            $display("FAIL b2b_rdy t=%0d: got %b want 1", t, rdy_o);
         end
      end
      checks++;
      if (dcnt !== 32'd0) begin
         errs++;
         $display("FAIL b2b_drops: got %0d want 0", dcnt);
      end
   endtask

   task automatic test_stall_hold();
      trdy = 8'hF7;
      dw   = 16'd0;
      for (int i = 0; i < 3; i++) begin
         vld = 1'b1;
         din = mk(20 + i, 3);
         tick();
      end
      vld = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (tvld[3] !== 1'b1 || tdata[3] !== mk(20, 3) || rdy_o !== 1'b0 ||
             drop !== 1'b0) begin
            errs++;
            $display("FAIL stall_hold i=%0d: vld=%b data=%h rdy=%b drop=%b want 1 %h 0 0",
                     i, tvld[3], tdata[3], rdy_o, drop, mk(20, 3));
         end
      end
      trdy = 8'hFF;
      tick();
      checks++;
      if (tvld !== 8'h08 || tdata[3] !== mk(21, 3) || rdy_o !== 1'b1) begin
         errs++;
         $display("FAIL stall_release_p2: vld=%h data=%h rdy=%b want 08 %h 1",
                  tvld, tdata[3], rdy_o, mk(21, 3));
      end
      tick();
      checks++;
      if (tvld !== 8'h08 || tdata[3] !== mk(22, 3)) begin
         errs++;
         $display("FAIL stall_release_p3: vld=%h data=%h want 08 %h",
                  tvld, tdata[3], mk(22, 3));
      end
      tick();
      checks++;
      if (tvld !== 8'h00 || dcnt !== 32'd0) begin
         errs++;
         $display("FAIL stall_release_idle: vld=%h cnt=%0d want 00 0", tvld, dcnt);
      end
   endtask

   task automatic test_drop_wait();
      trdy = 8'hDF;
      dw   = 16'd4;
      vld  = 1'b1;
      din  = mk(30, 5);
      tick();
      din  = mk(31, 5);
      tick();
      vld  = 1'b0;
      for (int t = 2; t <= 8; t++) begin
         tick();
         checks++;
         if (drop !== (t == 6)) begin
            errs++;
            $display("FAIL dw4_pulse edge=%0d: got %b want %b", t, drop, (t == 6));
         end
      end
      exp_drops = 1;
      checks++;
      if (dcnt !== 32'(exp_drops) || tvld[5] !== 1'b1 || tdata[5] !== mk(30, 5)) begin
         errs++;
         $display("FAIL dw4_state: cnt=%0d vld=%b data=%h want %0d 1 %h",
                  dcnt, tvld[5], tdata[5], exp_drops, mk(30, 5));
      end
      trdy = 8'hFF;
      dw   = 16'd0;
      tick();
      tick();
      checks++;
      if (tvld !== 8'h00) begin
         errs++;
         $display("FAIL dw4_drain: vld=%h want 00", tvld);
      end
   endtask

   task automatic test_drop_wait_one();
      trdy = 8'hBF;
      dw   = 16'd1;
      vld  = 1'b1;
      din  = mk(40, 6);
      tick();
      din  = mk(41, 6);
      tick();
      vld  = 1'b0;
      tick();
      checks++;
      if (drop !== 1'b0 || tvld[6] !== 1'b1) begin
         errs++;
         $display("FAIL dw1_edge2: drop=%b vld=%b want 0 1", drop, tvld[6]);
      end
      tick();
      checks++;
      if (drop !== 1'b1) begin
         errs++;
         $display("FAIL dw1_edge3: drop=%b want 1", drop);
      end
      tick();
      exp_drops = 2;
      checks++;
      if (drop !== 1'b0 || dcnt !== 32'(exp_drops) || tdata[6] !== mk(40, 6)) begin
         errs++;
         $display("FAIL dw1_after: drop=%b cnt=%0d data=%h want 0 %0d %h",
                  drop, dcnt, tdata[6], exp_drops, mk(40, 6));
      end
      trdy = 8'hFF;
      dw   = 16'd0;
      tick();
      tick();
   endtask

   task automatic test_link_down();
      trdy = 8'hFD;
      dw   = 16'd0;
      for (int i = 0; i < 3; i++) begin
         vld = 1'b1;
         din = mk(50 + i, 1);
         tick();
      end
      vld = 1'b0;
      tick();
      tick();
      checks++;
      if (tvld !== 8'h02 || tdata[1] !== mk(50, 1) || rdy_o !== 1'b0) begin
         errs++;
         $display("FAIL link_pre: vld=%h data=%h rdy=%b want 02 %h 0",
                  tvld, tdata[1], rdy_o, mk(50, 1));
      end
      hs = 1'b0;
      tick();
      checks++;
      if (tvld !== 8'h00 || drop !== 1'b1 || dcnt !== 32'(exp_drops + 1) ||
          rdy_o !== 1'b1) begin
         errs++;
         $display("FAIL link_down_1: vld=%h drop=%b cnt=%0d rdy=%b want 00 1 %0d 1",
                  tvld, drop, dcnt, rdy_o, exp_drops + 1);
      end
      tick();
      checks++;
      if (drop !== 1'b1 || dcnt !== 32'(exp_drops + 2)) begin
         errs++;
         $display("FAIL link_down_2: drop=%b cnt=%0d want 1 %0d",
                  drop, dcnt, exp_drops + 2);
      end
      tick();
      exp_drops = exp_drops + 2;
      checks++;
      if (drop !== 1'b0 || dcnt !== 32'(exp_drops) || tvld !== 8'h00) begin
         errs++;
         $display("FAIL link_down_3: drop=%b cnt=%0d vld=%h want 0 %0d 00",
                  drop, dcnt, tvld, exp_drops);
      end
      hs   = 1'b1;
      trdy = 8'hFF;
      vld  = 1'b1;
      din  = mk(53, 1);
      tick();
      vld  = 1'b0;
      tick();
      checks++;
      if (tvld !== 8'h00) begin
         errs++;
         $display("FAIL link_up_early: vld=%h want 00", tvld);
      end
      tick();
      checks++;
      if (tvld !== 8'h02 || tdata[1] !== mk(53, 1) || dcnt !== 32'(exp_drops)) begin
         errs++;
         $display("FAIL link_up_flow: vld=%h data=%h cnt=%0d want 02 %h %0d",
                  tvld, tdata[1], dcnt, mk(53, 1), exp_drops);
      end
      tick();
   endtask

   task automatic test_saturate();
      logic        ed;
      logic [31:0] ec;
      hs = 1'b0;
      force dut.drop_cnt_d = 32'hFFFF_FFFE;
      tick();
      release dut.drop_cnt_d;
      checks++;
      if (dcnt !== 32'hFFFF_FFFE) begin
         errs++;
         $display("FAIL sat_preload: cnt=%h want fffffffe", dcnt);
      end
      for (int t = 0; t < 6; t++) begin
         if (t < 3) begin
            vld = 1'b1;
            din = mk(60 + t, 0);
         end else begin
            vld = 1'b0;
         end
         tick();
         ed = (t >= 2) && (t <= 4);
         ec = (t >= 2) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
         checks++;
         if (drop !== ed || dcnt !== ec) begin
            errs++;
            $display("FAIL sat_drop t=%0d: drop=%b cnt=%h want %b %h",
                     t, drop, dcnt, ed, ec);
         end
      end
      hs = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      trdy = 8'hFB;
      for (int i = 0; i < 3; i++) begin
         vld = 1'b1;
         din = mk(70 + i, 2);
         tick();
      end
      vld = 1'b0;
      tick();
      checks++;
      if (tvld !== 8'h04 || rdy_o !== 1'b0) begin
         errs++;
         $display("FAIL rst_mid_pre: vld=%h rdy=%b want 04 0", tvld, rdy_o);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (tvld !== 8'h00 || rdy_o !== 1'b0 || drop !== 1'b0 || dcnt !== 32'd0) begin
         errs++;
         $display("FAIL rst_mid_async: vld=%h rdy=%b drop=%b cnt=%h want 00 0 0 0",
                  tvld, rdy_o, drop, dcnt);
      end
      tick();
      reset = 1'b0;
      trdy  = 8'hFF;
      #1;
      checks++;
      if (rdy_o !== 1'b0) begin
         errs++;
         $display("FAIL rst_mid_release: rdy=%b want 0", rdy_o);
      end
      tick();
      checks++;
      if (rdy_o !== 1'b1) begin
         errs++;
         $display("FAIL rst_mid_rdy: rdy=%b want 1", rdy_o);
      end
      tick();
      tick();
      checks++;
      if (tvld !== 8'h00 || drop !== 1'b0 || dcnt !== 32'd0) begin
         errs++;
         $display("FAIL rst_mid_empty: vld=%h drop=%b cnt=%0d want 00 0 0",
                  tvld, drop, dcnt);
      end
   endtask

   initial begin
      reset = 1'b1;
      hs    = 1'b1;
      dw    = 16'd0;
      din   = '0;
      vld   = 1'b0;
      trdy  = 8'hFF;
      test_reset();
      test_back_to_back();
      test_stall_hold();
      test_drop_wait();
      test_drop_wait_one();
      test_link_down();
      test_saturate();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
